// File: rtl/serial_fa_pkg.sv
// Shared types and sizing for the bit-serial full-adder sequencer.
package serial_fa_pkg;

    localparam int DEFAULT_WIDTH    = 8;
    localparam int DEFAULT_SETTLE_W = 4;
    localparam int IDX_W            = $clog2(DEFAULT_WIDTH);

    // state   | meaning
    // --------+---------------------------------------------
    // ST_IDLE | waiting for start, adder cell inputs at 0
    // ST_RUN  | presenting bits LSB first, sampling the cell
    // ST_DONE | one-cycle done pulse, result/cout valid
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Bit index width for a given operand width; never narrower than 1 bit.
    function automatic int idx_width(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/serial_fa_sequencer_settle_timer.sv
// Loadable down-counter that paces how long each bit is held on the adder cell.
module settle_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ena,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt_q;

    // Load takes priority; otherwise count down and stop at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (ena) begin
            if (load) begin
                cnt_q <= load_val;
            end else if (cnt_q != '0) begin
                cnt_q <= cnt_q - W'(1);
            end
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/serial_fa_sequencer.sv
// Time-shares one external 1-bit full-adder cell to build a WIDTH-bit sum,
// LSB first, holding each bit for settle+1 cycles before sampling.
module serial_fa_sequencer
    import serial_fa_pkg::*;
#(
    parameter  int WIDTH    = DEFAULT_WIDTH,
    parameter  int SETTLE_W = DEFAULT_SETTLE_W,
    localparam int IW       = idx_width(WIDTH)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ena,
    input  logic                start,
    input  logic                abort,
    input  logic [WIDTH-1:0]    op_a,
    input  logic [WIDTH-1:0]    op_b,
    input  logic                cin,
    input  logic [SETTLE_W-1:0] settle,
    input  logic                fa_sum,
    input  logic                fa_cout,
    output logic                fa_a,
    output logic                fa_b,
    output logic                fa_cin,
    output logic                busy,
    output logic                done,
    output logic [WIDTH-1:0]    result,
    output logic                cout,
    output logic [IW-1:0]       bit_idx
);

    state_t state_q, state_d;

    logic [WIDTH-1:0]    a_sr_q, a_sr_d, b_sr_q, b_sr_d;
    logic [WIDTH-1:0]    result_q, result_d;
    logic [SETTLE_W-1:0] settle_q, settle_d;
    logic [IW-1:0]       bit_idx_q, bit_idx_d;
    logic                carry_q, carry_d, cout_q, cout_d;
    logic                fa_a_q, fa_a_d, fa_b_q, fa_b_d, fa_cin_q, fa_cin_d;
    logic                timer_load, timer_zero;
    logic [SETTLE_W-1:0] timer_val;

    settle_timer #(.W(SETTLE_W)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .ena      (ena),
        .load     (timer_load),
        .load_val (timer_val),
        .zero     (timer_zero)
    );

    // State register; ena low freezes the sequencer in place.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   state_q <= ST_IDLE;
        else if (ena) state_q <= state_d;
    end

    // Next-state and datapath updates; cell inputs are precomputed so they leave registers.
    always_comb begin
        state_d    = state_q;
        a_sr_d     = a_sr_q;
        b_sr_d     = b_sr_q;
        result_d   = result_q;
        settle_d   = settle_q;
        bit_idx_d  = bit_idx_q;
        carry_d    = carry_q;
        cout_d     = cout_q;
        fa_a_d     = fa_a_q;
        fa_b_d     = fa_b_q;
        fa_cin_d   = fa_cin_q;
        timer_load = 1'b0;
        timer_val  = settle_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_sr_d     = op_a;
                    b_sr_d     = op_b;
                    carry_d    = cin;
                    settle_d   = settle;
                    bit_idx_d  = '0;
                    result_d   = '0;
                    timer_load = 1'b1;
                    timer_val  = settle;
                    fa_a_d     = op_a[0];
                    fa_b_d     = op_b[0];
                    fa_cin_d   = cin;
                    state_d    = ST_RUN;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    fa_a_d   = 1'b0;
                    fa_b_d   = 1'b0;
                    fa_cin_d = 1'b0;
                    state_d  = ST_IDLE;
                end else if (timer_zero) begin
                    result_d   = {fa_sum, result_q[WIDTH-1:1]};
                    carry_d    = fa_cout;
                    a_sr_d     = a_sr_q >> 1;
                    b_sr_d     = b_sr_q >> 1;
                    timer_load = 1'b1;
                    if (bit_idx_q == IW'(WIDTH - 1)) begin
                        cout_d   = fa_cout;
                        fa_a_d   = 1'b0;
                        fa_b_d   = 1'b0;
                        fa_cin_d = 1'b0;
                        state_d  = ST_DONE;
                    end else begin
                        bit_idx_d = bit_idx_q + IW'(1);
                        fa_a_d    = a_sr_q[1];
                        fa_b_d    = b_sr_q[1];
                        fa_cin_d  = fa_cout;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath registers, all cleared by reset and frozen while ena is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr_q    <= '0;
            b_sr_q    <= '0;
            result_q  <= '0;
            settle_q  <= '0;
            bit_idx_q <= '0;
            carry_q   <= 1'b0;
            cout_q    <= 1'b0;
            fa_a_q    <= 1'b0;
            fa_b_q    <= 1'b0;
            fa_cin_q  <= 1'b0;
        end else if (ena) begin
            a_sr_q    <= a_sr_d;
            b_sr_q    <= b_sr_d;
            result_q  <= result_d;
            settle_q  <= settle_d;
            bit_idx_q <= bit_idx_d;
            carry_q   <= carry_d;
            cout_q    <= cout_d;
            fa_a_q    <= fa_a_d;
            fa_b_q    <= fa_b_d;
            fa_cin_q  <= fa_cin_d;
        end
    end

    assign busy    = (state_q == ST_RUN);
    assign done    = (state_q == ST_DONE);
    assign result  = result_q;
    assign cout    = cout_q;
    assign bit_idx = bit_idx_q;
    assign fa_a    = fa_a_q;
    assign fa_b    = fa_b_q;
    assign fa_cin  = fa_cin_q;

endmodule

// File: tb/tb_serial_fa_sequencer.sv
// Bench for serial_fa_sequencer with a behavioural full-adder cell of configurable delay.
module tb_serial_fa_sequencer;

    localparam int W  = 8;
    localparam int SW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ena, start, abort, cin;
    logic [W-1:0]  op_a, op_b;
    logic [SW-1:0] settle;
    logic          fa_sum, fa_cout, fa_a, fa_b, fa_cin;
    logic          busy, done, cout;
    logic [W-1:0]  result;
    logic [2:0]    bit_idx;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int fa_delay = 0;
    logic last_cout = 1'b0;

    logic [2:0] hist [4] = '{default: 3'b000};
    logic [2:0] cell_in;

    serial_fa_sequencer #(.WIDTH(W), .SETTLE_W(SW)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .start   (start),
        .abort   (abort),
        .op_a    (op_a),
        .op_b    (op_b),
        .cin     (cin),
        .settle  (settle),
        .fa_sum  (fa_sum),
        .fa_cout (fa_cout),
        .fa_a    (fa_a),
        .fa_b    (fa_b),
        .fa_cin  (fa_cin),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .cout    (cout),
        .bit_idx (bit_idx)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Input history of the model cell: hist[n] is what was presented n+1 cycles back.
    always @(posedge clk) begin
        for (int k = 3; k > 0; k--) hist[k] <= hist[k-1];
        hist[0] <= {fa_a, fa_b, fa_cin};
    end

    // Behavioural full adder whose outputs lag its inputs by fa_delay cycles.
    always_comb begin
        cell_in = {fa_a, fa_b, fa_cin};
        if (fa_delay > 0) cell_in = hist[fa_delay-1];
        fa_sum  = ^cell_in;
        fa_cout = (cell_in[2] & cell_in[1]) | (cell_in[2] & cell_in[0]) | (cell_in[1] & cell_in[0]);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One addition; gap_at/abort_at/ss_at are effective-cycle offsets (-1 = unused).
    task automatic do_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                          input int s, input int gap_at, input int abort_at, input int ss_at,
                          input bit chk_fa, input bit expect_ok);
        int lat, k, bi, stalls, c0, m, ai, bb, mask, cin_i, partial;
        logic [W:0] full;
        ai = int'(a);
        bb = int'(b);
        full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
        op_a = a; op_b = b; cin = ci; settle = SW'(s); start = 1'b1;
        tick();
        start = 1'b0;
        op_a = W'($urandom); op_b = W'($urandom); cin = 1'($urandom); settle = SW'($urandom);
        c0 = cyc;
        lat = W * (s + 1);
        k = 0;
        stalls = 0;
        while (k < lat) begin
            bi = k / (s + 1);
            mask = (1 << bi) - 1;
            cin_i = (((ai & mask) + (bb & mask) + int'(ci)) >> bi) & 1;
            check("busy", 32'(busy), 1);
            check("done_low", 32'(done), 0);
            check("bit_idx", 32'(bit_idx), bi);
            if (chk_fa) begin
                check("fa_a", 32'(fa_a), (ai >> bi) & 1);
                check("fa_b", 32'(fa_b), (bb >> bi) & 1);
                check("fa_cin", 32'(fa_cin), cin_i);
            end
            if (k == gap_at) begin
                ena = 1'b0;
                repeat (5) begin
                    tick();
                    stalls++;
                    check("frz_busy", 32'(busy), 1);
                    check("frz_idx", 32'(bit_idx), bi);
                    if (chk_fa) check("frz_fa_a", 32'(fa_a), (ai >> bi) & 1);
                end
                ena = 1'b1;
            end
            if (k == abort_at) begin
                m = k / (s + 1);
                partial = (m == 0) ? 0 : (((int'(full) & ((1 << m) - 1)) << (W - m)) & 'hFF);
                abort = 1'b1;
                tick();
                abort = 1'b0;
                check("abort_busy", 32'(busy), 0);
                check("abort_done", 32'(done), 0);
                check("abort_result", 32'(result), partial);
                check("abort_cout", 32'(cout), 32'(last_cout));
                tick();
                check("abort_done2", 32'(done), 0);
                check("abort_idle", 32'(busy), 0);
                return;
            end
            if (k == ss_at) begin
                op_a = W'(1);
                start = 1'b1;
            end
            tick();
            start = 1'b0;
            k++;
        end
        check("done", 32'(done), 1);
        check("busy_end", 32'(busy), 0);
        check("latency", 32'(cyc - c0), 32'(lat + stalls));
        if (expect_ok) begin
            check("result", 32'(result), 32'(full[W-1:0]));
            check("cout", 32'(cout), 32'(full[W]));
            last_cout = full[W];
        end else begin
            check("result_wrong", 32'(result == full[W-1:0]), 0);
        end
        // start during DONE must not launch a new run
        start = 1'b1;
        tick();
        start = 1'b0;
        check("done_pulse", 32'(done), 0);
        check("done_no_restart", 32'(busy), 0);
        if (expect_ok) check("result_hold", 32'(result), 32'(full[W-1:0]));
        tick();
        check("idle_after", 32'(busy), 0);
    endtask

    initial begin
        ena = 1'b1; start = 1'b0; abort = 1'b0; cin = 1'b0;
        op_a = '0; op_b = '0; settle = '0;
        #1;
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_result", 32'(result), 0);
        check("rst_cout", 32'(cout), 0);
        check("rst_idx", 32'(bit_idx), 0);
        check("rst_fa", {29'd0, fa_a, fa_b, fa_cin}, 0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        tick();

        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("idle_abort", 32'(busy), 0);

        do_add(8'h5A, 8'h3C, 1'b0, 0, -1, -1, -1, 1, 1);
        do_add(8'hFF, 8'h01, 1'b0, 0, -1, -1, -1, 1, 1);
        do_add(8'h00, 8'h00, 1'b1, 0, -1, -1, -1, 1, 1);
        do_add(8'h12, 8'h34, 1'b0, 3, -1, -1, -1, 1, 1);
        do_add(8'hA7, 8'h6D, 1'b1, 15, -1, -1, -1, 1, 1);

        // start while busy is ignored
        do_add(8'h81, 8'h7F, 1'b0, 1, -1, -1, 5, 1, 1);

        // abort on the first cycle of bit 3, racing the bit-3 sample
        do_add(8'hC3, 8'h5E, 1'b1, 0, -1, 3, -1, 1, 1);
        do_add(8'h2B, 8'h91, 1'b0, 0, -1, -1, -1, 1, 1);
        do_add(8'h77, 8'h99, 1'b1, 2, -1, 10, -1, 1, 1);
        do_add(8'h0F, 8'hF1, 1'b0, 1, -1, -1, -1, 1, 1);

        // ena low for 5 cycles mid-run
        do_add(8'h6C, 8'h3B, 1'b1, 2, 7, -1, -1, 1, 1);

        // asynchronous reset mid-run
        op_a = 8'hAA; op_b = 8'h55; cin = 1'b1; settle = 4'd1; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        #2 rst_n = 1'b0;
        #1;
        check("mrst_busy", 32'(busy), 0);
        check("mrst_done", 32'(done), 0);
        check("mrst_result", 32'(result), 0);
        check("mrst_cout", 32'(cout), 0);
        check("mrst_idx", 32'(bit_idx), 0);
        check("mrst_fa", {29'd0, fa_a, fa_b, fa_cin}, 0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        last_cout = 1'b0;
        tick();
        check("mrst_no_done", 32'(done), 0);
        check("mrst_idle", 32'(busy), 0);
        do_add(8'h3D, 8'hC4, 1'b0, 0, -1, -1, -1, 1, 1);

        // slow cell: too little settle gives a wrong sum, enough settle fixes it
        fa_delay = 2;
        do_add(8'h5A, 8'h3C, 1'b0, 0, -1, -1, -1, 0, 0);
        do_add(8'h5A, 8'h3C, 1'b0, 2, -1, -1, -1, 0, 1);
        fa_delay = 0;

        for (int i = 0; i < 8; i++) begin
            do_add(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 15)),
                   -1, -1, -1, 1, 1);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
